// File: rtl/frame_pipeline_if.sv
// Handshake and result bus between the frame pipeline sequencer and the
// capture / binary-filter / min-max engines.
//   master : the sequencer (drives start/ack, receives done flags and box)
//   slave  : the engine side (drives done flags and box, receives start/ack)
interface frame_pipeline_if;
    logic       photo_start;
    logic       photo_ack;
    logic       photo_done;
    logic       filter_start;
    logic       filter_ack;
    logic       filter_done;
    logic       min_max_start;
    logic       min_max_ack;
    logic       min_max_done;
    logic [8:0] x_min;
    logic [8:0] x_max;
    logic [8:0] y_min;
    logic [8:0] y_max;

    modport master (
        output photo_start, photo_ack,
        output filter_start, filter_ack,
        output min_max_start, min_max_ack,
        input  photo_done, filter_done, min_max_done,
        input  x_min, x_max, y_min, y_max
    );

    modport slave (
        input  photo_start, photo_ack,
        input  filter_start, filter_ack,
        input  min_max_start, min_max_ack,
        output photo_done, filter_done, min_max_done,
        output x_min, x_max, y_min, y_max
    );
endinterface

// File: rtl/frame_pipeline_ctrl.sv
// Frame pipeline sequencer: capture -> binary filter -> min/max search,
// each through a start/done/ack handshake, then latches the bounding box
// and swaps the ping-pong display/capture buffers.
//
// Optional build macro: FPC_WATCHDOG_EN
//   defined   : per-phase watchdog; a phase stuck for TIMEOUT_CYCLES cycles
//               parks the FSM in ERR until clr_err.
//   undefined : phases wait forever, error is constant 0, clr_err ignored.
module frame_pipeline_ctrl #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int FC_W           = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                run,
    input  logic                clr_err,
    frame_pipeline_if.master    pipe,
    output logic                image_sel,
    output logic [8:0]          bbox_x_min,
    output logic [8:0]          bbox_x_max,
    output logic [8:0]          bbox_y_min,
    output logic [8:0]          bbox_y_max,
    output logic                bbox_valid,
    output logic [FC_W-1:0]     frame_count,
    output logic                busy,
    output logic                error,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CAP     = 4'd1,
        CAP_ACK = 4'd2,
        FLT     = 4'd3,
        FLT_ACK = 4'd4,
        MM      = 4'd5,
        MM_ACK  = 4'd6,
        SWAP    = 4'd7,
        ERR     = 4'd8
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Done-flag synchronizers: bit 0 photo, bit 1 filter, bit 2 min/max.
    // ------------------------------------------------------------------
    logic [2:0] done_raw;
    logic [2:0] done_sync;

    assign done_raw = {pipe.min_max_done, pipe.filter_done, pipe.photo_done};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_done_sync
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchronizer for one engine's done flag
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= done_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign done_sync[gi] = sync_reg;
        end
    endgenerate

    logic ds_photo_done;
    logic ds_filter_done;
    logic ds_min_max_done;

    assign ds_photo_done   = done_sync[0];
    assign ds_filter_done  = done_sync[1];
    assign ds_min_max_done = done_sync[2];

    // States in which an engine handshake is outstanding (watchdog counts here)
    logic phase_active;
    assign phase_active = (state_reg == CAP)     || (state_reg == CAP_ACK) ||
                          (state_reg == FLT)     || (state_reg == FLT_ACK) ||
                          (state_reg == MM)      || (state_reg == MM_ACK);

    // ------------------------------------------------------------------
    // Optional per-phase watchdog
    // ------------------------------------------------------------------
    logic timeout;

`ifdef FPC_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            error_reg;

    assign timeout = (wd_cnt_reg == WD_LAST);
    assign error   = error_reg;

    // Phase cycle counter restarts on every state change; error mirrors ERR
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                wd_cnt_reg <= '0;
            end else if (phase_active) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            error_reg <= (state_next == ERR);
        end
    end
`else
    // Watchdog absent: the limit is only referenced to keep the parameter
    // visible in both builds.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
    assign error              = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Phase sequencing; a watchdog expiry overrides any handshake progress
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (run)              state_next = CAP;
            CAP:     if (ds_photo_done)    state_next = CAP_ACK;
            CAP_ACK: if (!ds_photo_done)   state_next = FLT;
            FLT:     if (ds_filter_done)   state_next = FLT_ACK;
            FLT_ACK: if (!ds_filter_done)  state_next = MM;
            MM:      if (ds_min_max_done)  state_next = MM_ACK;
            MM_ACK:  if (!ds_min_max_done) state_next = SWAP;
            SWAP:    state_next = run ? CAP : IDLE;
            ERR:     if (clr_err)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (phase_active && timeout) begin
            state_next = ERR;
        end
    end

    // ------------------------------------------------------------------
    // State register and registered outputs, all decoded from state_next
    // so every output changes on the same edge as the transition.
    // ------------------------------------------------------------------
    // FSM state, handshake outputs, box latch and buffer swap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg          <= IDLE;
            state_dbg          <= 4'd0;
            busy               <= 1'b0;
            pipe.photo_start   <= 1'b0;
            pipe.photo_ack     <= 1'b0;
            pipe.filter_start  <= 1'b0;
            pipe.filter_ack    <= 1'b0;
            pipe.min_max_start <= 1'b0;
            pipe.min_max_ack   <= 1'b0;
            bbox_x_min         <= 9'd0;
            bbox_x_max         <= 9'd0;
            bbox_y_min         <= 9'd0;
            bbox_y_max         <= 9'd0;
            bbox_valid         <= 1'b0;
            image_sel          <= 1'b1;
            frame_count        <= '0;
        end else begin
            state_reg          <= state_next;
            state_dbg          <= state_next;
            busy               <= (state_next != IDLE) && (state_next != ERR);
            pipe.photo_start   <= (state_next == CAP);
            pipe.photo_ack     <= (state_next == CAP_ACK);
            pipe.filter_start  <= (state_next == FLT);
            pipe.filter_ack    <= (state_next == FLT_ACK);
            pipe.min_max_start <= (state_next == MM);
            pipe.min_max_ack   <= (state_next == MM_ACK);

            // The box inputs are only guaranteed stable while done is high,
            // so capture them on the edge that acknowledges that done.
            if ((state_reg == MM) && (state_next == MM_ACK)) begin
                bbox_x_min <= pipe.x_min;
                bbox_x_max <= pipe.x_max;
                bbox_y_min <= pipe.y_min;
                bbox_y_max <= pipe.y_max;
                bbox_valid <= (pipe.x_min <= pipe.x_max) &&
                              (pipe.y_min <= pipe.y_max);
            end

            // SWAP is entered only from MM_ACK and always left after one
            // cycle, so this fires exactly once per completed frame.
            if (state_next == SWAP) begin
                image_sel   <= ~image_sel;
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_pipeline_ctrl.sv
// Directed bench for frame_pipeline_ctrl: a vector table of bounding boxes
// run as complete frames, plus hand-written run-drop, early-done, watchdog
// (or indefinite wait without FPC_WATCHDOG_EN) and asynchronous reset cases.
module tb_frame_pipeline_ctrl;

    localparam int FC_W = 16;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CAP     = 4'd1;
    localparam logic [3:0] S_CAP_ACK = 4'd2;
    localparam logic [3:0] S_FLT     = 4'd3;
    localparam logic [3:0] S_FLT_ACK = 4'd4;
    localparam logic [3:0] S_MM      = 4'd5;
    localparam logic [3:0] S_MM_ACK  = 4'd6;
    localparam logic [3:0] S_SWAP    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

    logic            clk = 1'b0;
    logic            resetn;
    logic            run;
    logic            clr_err;
    logic            image_sel;
    logic [8:0]      bbox_x_min;
    logic [8:0]      bbox_x_max;
    logic [8:0]      bbox_y_min;
    logic [8:0]      bbox_y_max;
    logic            bbox_valid;
    logic [FC_W-1:0] frame_count;
    logic            busy;
    logic            error;
    logic [3:0]      state_dbg;

    int   checks = 0;
    int   errors = 0;
    logic exp_sel;
    int   exp_fc;
    int   hs_viol  = 0;
    int   sel_viol = 0;
    logic prev_sel = 1'b1;

    typedef struct {
        logic [8:0] x_min;
        logic [8:0] x_max;
        logic [8:0] y_min;
        logic [8:0] y_max;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [6];

    frame_pipeline_if pif ();

    frame_pipeline_ctrl #(
        .TIMEOUT_CYCLES (100),
        .FC_W           (FC_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .clr_err     (clr_err),
        .pipe        (pif),
        .image_sel   (image_sel),
        .bbox_x_min  (bbox_x_min),
        .bbox_x_max  (bbox_x_max),
        .bbox_y_min  (bbox_y_min),
        .bbox_y_max  (bbox_y_max),
        .bbox_valid  (bbox_valid),
        .frame_count (frame_count),
        .busy        (busy),
        .error       (error),
        .state_dbg   (state_dbg)
    );

    // 25 MHz
    always #20 clk = ~clk;

    logic [5:0] hs_all;
    assign hs_all = {pif.min_max_ack, pif.min_max_start,
                     pif.filter_ack,  pif.filter_start,
                     pif.photo_ack,   pif.photo_start};

    // Background watch: at most one start/ack high, and the displayed
    // buffer never flips while capture is requested.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if ($countones(hs_all) > 1) hs_viol = hs_viol + 1;
            if ((image_sel !== prev_sel) && (pif.photo_start === 1'b1)) sel_viol = sel_viol + 1;
        end
        prev_sel = image_sel;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {ack, start} of phase p (0 photo, 1 filter, 2 min/max)
    function automatic logic [1:0] hs(input int p);
        return hs_all[2*p +: 2];
    endfunction

    task automatic set_done(input int p, input logic v);
        case (p)
            0:       pif.photo_done   = v;
            1:       pif.filter_done  = v;
            default: pif.min_max_done = v;
        endcase
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n = 0;
        while ((state_dbg !== s) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_state_%0d", s), 32'(state_dbg), 32'(s));
    endtask

    // Engine model for one phase: answer start with done after 'delay'
    // cycles, then release done 'delay' cycles after the ack.
    task automatic do_phase(input int p, input int delay);
        logic [3:0] run_s;
        logic [3:0] ack_s;
        run_s = 4'(1 + 2*p);
        ack_s = 4'(2 + 2*p);
        wait_state(run_s, 50);
        chk($sformatf("start_p%0d", p), 32'(hs(p)), 32'(2'b01));
        repeat (delay) @(negedge clk);
        set_done(p, 1'b1);
        wait_state(ack_s, 10);
        chk($sformatf("ack_p%0d", p), 32'(hs(p)), 32'(2'b10));
        repeat (delay) @(negedge clk);
        set_done(p, 1'b0);
    endtask

    task automatic check_swap(input string tag);
        wait_state(S_SWAP, 10);
        exp_sel = ~exp_sel;
        exp_fc  = exp_fc + 1;
        chk({tag, "_image_sel"},   32'(image_sel),   32'(exp_sel));
        chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        pif.x_min = v.x_min;
        pif.x_max = v.x_max;
        pif.y_min = v.y_min;
        pif.y_max = v.y_max;
        do_phase(0, 10);
        do_phase(1, 10);
        do_phase(2, 10);
        check_swap($sformatf("frame%0d", idx));
        chk("bbox_x_min", 32'(bbox_x_min), 32'(v.x_min));
        chk("bbox_x_max", 32'(bbox_x_max), 32'(v.x_max));
        chk("bbox_y_min", 32'(bbox_y_min), 32'(v.y_min));
        chk("bbox_y_max", 32'(bbox_y_max), 32'(v.y_max));
        chk("bbox_valid", 32'(bbox_valid), 32'(v.exp_valid));
        chk("busy_swap",  32'(busy),       32'd1);
        @(negedge clk);
        chk("swap_to_cap", 32'(state_dbg), 32'(S_CAP));
        $display("frame %0d: box x %0d..%0d y %0d..%0d valid=%0d sel=%0d count=%0d",
                 idx, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
                 bbox_valid, image_sel, frame_count);
    endtask

    initial begin
        int n;

        vecs[0] = '{9'd20,  9'd100, 9'd5,  9'd60,  1'b1};
        vecs[1] = '{9'd300, 9'd0,   9'd5,  9'd60,  1'b0};
        vecs[2] = '{9'd7,   9'd7,   9'd9,  9'd9,   1'b1};
        vecs[3] = '{9'd10,  9'd20,  9'd60, 9'd5,   1'b0};
        vecs[4] = '{9'd0,   9'd511, 9'd0,  9'd511, 1'b1};
        vecs[5] = '{9'd511, 9'd510, 9'd0,  9'd0,   1'b0};

        resetn           = 1'b0;
        run              = 1'b0;
        clr_err          = 1'b0;
        pif.photo_done   = 1'b0;
        pif.filter_done  = 1'b0;
        pif.min_max_done = 1'b0;
        pif.x_min        = 9'd0;
        pif.x_max        = 9'd0;
        pif.y_min        = 9'd0;
        pif.y_max        = 9'd0;
        exp_sel          = 1'b1;
        exp_fc           = 0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("rst_state",       32'(state_dbg),   32'(S_IDLE));
        chk("rst_image_sel",   32'(image_sel),   32'd1);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_error",       32'(error),       32'd0);
        chk("rst_bbox_valid",  32'(bbox_valid),  32'd0);
        chk("rst_handshake",   32'(hs_all),      32'd0);
        $display("reset: state=%0d sel=%0d count=%0d", state_dbg, image_sel, frame_count);

        resetn = 1'b1;
        run    = 1'b1;

        // ---- table of boxes, one full frame each ----
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], i);
        end

        // ---- run dropped during FLT: frame completes, then idle ----
        do_phase(0, 10);
        wait_state(S_FLT, 20);
        run = 1'b0;
        do_phase(1, 10);
        do_phase(2, 10);
        check_swap("rundrop");
        @(negedge clk);
        chk("rundrop_idle", 32'(state_dbg), 32'(S_IDLE));
        chk("rundrop_busy", 32'(busy),      32'd0);
        repeat (20) @(negedge clk);
        chk("rundrop_stay_idle", 32'(state_dbg),   32'(S_IDLE));
        chk("rundrop_count",     32'(frame_count), 32'(exp_fc));
        $display("run-drop frame: state=%0d busy=%0d count=%0d", state_dbg, busy, frame_count);

        // ---- photo_done raised in the first CAP cycle and held ----
        run = 1'b1;
        @(negedge clk);
        chk("early_cap", 32'(state_dbg), 32'(S_CAP));
        pif.photo_done = 1'b1;
        n = 0;
        while ((pif.photo_start === 1'b1) && (n < 20)) begin
            n++;
            @(negedge clk);
        end
        chk("early_start_cycles", 32'(n), 32'd3);
        chk("early_ack_state",    32'(state_dbg), 32'(S_CAP_ACK));
        chk("early_hs",           32'(hs(0)), 32'(2'b10));
        repeat (5) begin
            @(negedge clk);
            chk("early_ack_held", 32'(hs(0)), 32'(2'b10));
        end
        pif.photo_done = 1'b0;
        n = 0;
        while ((pif.photo_ack === 1'b1) && (n < 20)) begin
            n++;
            @(negedge clk);
        end
        chk("early_ack_release", 32'(n), 32'd3);
        chk("early_to_flt",      32'(state_dbg), 32'(S_FLT));
        do_phase(1, 10);
        do_phase(2, 10);
        check_swap("early");
        $display("early-done frame: start width ok, count=%0d sel=%0d", frame_count, image_sel);

        // ---- filter never answers ----
        do_phase(0, 10);
        wait_state(S_FLT, 20);
`ifdef FPC_WATCHDOG_EN
        repeat (99) @(negedge clk);
        chk("wd_still_flt", 32'(state_dbg), 32'(S_FLT));
        @(negedge clk);
        chk("wd_err_state",   32'(state_dbg),   32'(S_ERR));
        chk("wd_error",       32'(error),       32'd1);
        chk("wd_image_sel",   32'(image_sel),   32'(exp_sel));
        chk("wd_frame_count", 32'(frame_count), 32'(exp_fc));
        chk("wd_handshake",   32'(hs_all),      32'd0);
        chk("wd_busy",        32'(busy),        32'd0);
        run = 1'b0;
        repeat (5) @(negedge clk);
        chk("wd_err_sticky", 32'(error), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("wd_clr_state", 32'(state_dbg), 32'(S_IDLE));
        chk("wd_clr_error", 32'(error),     32'd0);
        $display("watchdog: ERR reached, cleared to state=%0d error=%0d", state_dbg, error);
        run = 1'b1;
        do_phase(0, 10);
        do_phase(1, 10);
`else
        repeat (150) @(negedge clk);
        chk("nowd_still_flt", 32'(state_dbg), 32'(S_FLT));
        chk("nowd_error",     32'(error),     32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("nowd_clr_ignored", 32'(state_dbg), 32'(S_FLT));
        chk("nowd_error_after", 32'(error),     32'd0);
        $display("no watchdog: FLT held 150 cycles, state=%0d error=%0d", state_dbg, error);
        pif.filter_done = 1'b1;
        wait_state(S_FLT_ACK, 10);
        pif.filter_done = 1'b0;
`endif

        // ---- asynchronous reset during MM_ACK ----
        pif.x_min = 9'd20;
        pif.x_max = 9'd100;
        pif.y_min = 9'd5;
        pif.y_max = 9'd60;
        wait_state(S_MM, 20);
        pif.min_max_done = 1'b1;
        wait_state(S_MM_ACK, 10);
        chk("pre_rst_bbox_valid", 32'(bbox_valid), 32'd1);
        #5;
        resetn = 1'b0;
        #1;
        chk("arst_state",       32'(state_dbg),   32'(S_IDLE));
        chk("arst_image_sel",   32'(image_sel),   32'd1);
        chk("arst_frame_count", 32'(frame_count), 32'd0);
        chk("arst_handshake",   32'(hs_all),      32'd0);
        chk("arst_bbox_x_max",  32'(bbox_x_max),  32'd0);
        chk("arst_bbox_valid",  32'(bbox_valid),  32'd0);
        chk("arst_busy",        32'(busy),        32'd0);
        $display("async reset in MM_ACK: state=%0d sel=%0d count=%0d", state_dbg, image_sel, frame_count);
        pif.min_max_done = 1'b0;
        run = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        chk("handshake_onehot_violations", 32'(hs_viol),  32'd0);
        chk("sel_during_capture",          32'(sel_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #3ms;
        $display("FAIL global_timeout: got no finish, expected finish before 3 ms");
        $fatal(1, "timeout");
    end

endmodule
